// File: rtl/sha256_pkg.sv
// Shared constants, state encoding and byte-lane helper for the SHA-256 padder.
package sha256_pkg;

    localparam int unsigned BLOCK_BYTES = 64;
    localparam int unsigned LEN_BYTES   = 8;
    localparam int unsigned BLOCK_W     = BLOCK_BYTES * 8;
    localparam int unsigned IDX_W       = 6;
    localparam int unsigned NB_W        = 7;

    localparam logic [255:0] IV_INIT =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    typedef enum logic [2:0] {
        ST_FILL,
        ST_LOAD,
        ST_SEND,
        ST_WAIT,
        ST_PAD,
        ST_DONE
    } state_t;

    // Top bit of byte lane k in a big-endian block (byte 0 is the MSB byte).
    function automatic logic [8:0] lane_hi(input logic [NB_W-1:0] k);
        return 9'(BLOCK_W - 1 - 8 * int'(k));
    endfunction

endpackage

// File: rtl/sha256_padder.sv
// Byte-stream front end for the SHA-256 core: pads, packs 512-bit blocks,
// sequences load/gen/block_ready and captures the final digest.
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int unsigned  LEN_W = 64,
    parameter logic [255:0] IV    = IV_INIT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    input  logic         in_empty,
    output logic         core_load_hash,
    output logic [255:0] core_hash_in,
    output logic         core_gen_hash,
    output logic [511:0] core_msg,
    input  logic         core_block_ready,
    input  logic [255:0] core_hash_out,
    output logic [255:0] digest,
    output logic         digest_valid,
    output logic         busy
);

    localparam int unsigned GAP_W = BLOCK_W - 8 - LEN_BYTES * 8;

    state_t             state;
    logic [BLOCK_W-1:0] blk;
    logic [IDX_W-1:0]   idx;
    logic [NB_W-1:0]    n_bytes;
    logic [LEN_W-1:0]   len;
    logic               loaded;
    logic               final_blk;
    logic               pad2;

    logic xfer;
    logic data_beat;

    assign xfer         = in_valid & in_ready & (state == ST_FILL);
    assign data_beat    = xfer & ~in_empty;
    assign core_hash_in = IV;
    assign core_msg     = blk;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_FILL;
            blk            <= '0;
            idx            <= '0;
            n_bytes        <= '0;
            len            <= '0;
            loaded         <= 1'b0;
            final_blk      <= 1'b0;
            pad2           <= 1'b0;
            in_ready       <= 1'b0;
            core_load_hash <= 1'b0;
            core_gen_hash  <= 1'b0;
            digest         <= '0;
            digest_valid   <= 1'b0;
            busy           <= 1'b0;
        end else begin
            core_load_hash <= 1'b0;
            core_gen_hash  <= 1'b0;
            digest_valid   <= 1'b0;

            case (state)
                ST_FILL: begin
                    in_ready <= 1'b1;
                    if (data_beat) begin
                        blk[lane_hi(NB_W'(idx)) -: 8] <= in_data;
                        idx  <= idx + IDX_W'(1);
                        len  <= len + LEN_W'(8);
                        busy <= 1'b1;
                    end
                    if (xfer && in_last) begin
                        n_bytes  <= NB_W'(idx) + NB_W'(data_beat);
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ST_PAD;
                    end else if (data_beat && idx == IDX_W'(BLOCK_BYTES - 1)) begin
                        in_ready <= 1'b0;
                        if (loaded) begin
                            state         <= ST_SEND;
                            core_gen_hash <= 1'b1;
                        end else begin
                            state          <= ST_LOAD;
                            core_load_hash <= 1'b1;
                        end
                    end
                end

                // Marker and length land here; an overflowing tail defers to a second block.
                ST_PAD: begin
                    if (n_bytes <= NB_W'(55)) begin
                        blk[lane_hi(n_bytes) -: 8] <= 8'h80;
                        blk[LEN_BYTES*8-1:0]       <= 64'(len);
                        final_blk                  <= 1'b1;
                    end else if (n_bytes <= NB_W'(63)) begin
                        blk[lane_hi(n_bytes) -: 8] <= 8'h80;
                        pad2                       <= 1'b1;
                    end else begin
                        pad2 <= 1'b1;
                    end
                    if (loaded) begin
                        state         <= ST_SEND;
                        core_gen_hash <= 1'b1;
                    end else begin
                        state          <= ST_LOAD;
                        core_load_hash <= 1'b1;
                    end
                end

                ST_LOAD: begin
                    loaded        <= 1'b1;
                    state         <= ST_SEND;
                    core_gen_hash <= 1'b1;
                end

                ST_SEND: begin
                    state <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (core_block_ready) begin
                        if (final_blk) begin
                            digest       <= core_hash_out;
                            digest_valid <= 1'b1;
                            state        <= ST_DONE;
                        end else if (pad2) begin
                            blk <= {(n_bytes == NB_W'(64)) ? 8'h80 : 8'h00,
                                    {GAP_W{1'b0}}, 64'(len)};
                            pad2          <= 1'b0;
                            final_blk     <= 1'b1;
                            state         <= ST_SEND;
                            core_gen_hash <= 1'b1;
                        end else begin
                            blk      <= '0;
                            in_ready <= 1'b1;
                            state    <= ST_FILL;
                        end
                    end
                end

                ST_DONE: begin
                    blk       <= '0;
                    idx       <= '0;
                    n_bytes   <= '0;
                    len       <= '0;
                    loaded    <= 1'b0;
                    final_blk <= 1'b0;
                    pad2      <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= ST_FILL;
                end

                default: begin
                    state <= ST_FILL;
                end
            endcase
        end
    end

endmodule
